// File: rtl/booth_pkg.sv
// booth_pkg: shared types and sizing helpers for the sequential Booth multiplier.
// Build option: define BOOTH_RADIX4_EN for modified Booth radix-4 recoding;
// leave it undefined for the plain radix-2 datapath.
package booth_pkg;

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  // Radix-4 digit for {q[1], q[0], q0}: 0, +1, +1, +2, -2, -1, -1, 0
  localparam int R4_DIGIT [8] = '{0, 1, 1, 2, -2, -1, -1, 0};

  // Internal operand width after sign/zero extension
  function automatic int booth_n(input int width);
`ifdef BOOTH_RADIX4_EN
    return width + 2;
`else
    return width + 1;
`endif
  endfunction

  // Accumulator width; radix-4 carries one guard bit for the +/-2M digits
  function automatic int booth_aw(input int width);
`ifdef BOOTH_RADIX4_EN
    return width + 3;
`else
    return width + 1;
`endif
  endfunction

  // Number of Booth steps per product
  function automatic int booth_iter(input int width);
`ifdef BOOTH_RADIX4_EN
    return (width + 2) / 2;
`else
    return width + 1;
`endif
  endfunction

endpackage

// File: rtl/booth_mult_seq_if.sv
// booth_mult_seq_if: operand/result handshake bundle for booth_mult_seq.
// The master side supplies operands and consumes results; the slave is the multiplier.
interface booth_mult_seq_if #(
  parameter int WIDTH = 8
);

  logic               clear;
  logic               in_valid;
  logic               in_ready;
  logic               is_signed;
  logic [WIDTH-1:0]   M;
  logic [WIDTH-1:0]   Q;
  logic               out_valid;
  logic               out_ready;
  logic [2*WIDTH-1:0] result;
  logic               busy;

  modport master (
    output clear, in_valid, is_signed, M, Q, out_ready,
    input  in_ready, out_valid, result, busy
  );

  modport slave (
    input  clear, in_valid, is_signed, M, Q, out_ready,
    output in_ready, out_valid, result, busy
  );

endinterface

// File: rtl/booth_step.sv
// booth_step: one purely combinational Booth iteration (add/subtract, then arithmetic shift).
// Build option: BOOTH_RADIX4_EN selects the radix-4 step (shift by 2), otherwise radix-2.
module booth_step
  import booth_pkg::*;
#(
  parameter int N  = 9,
  parameter int AW = 9
) (
  input  logic [AW-1:0] a,
  input  logic [N-1:0]  q_reg,
  input  logic          q0,
  input  logic [N-1:0]  m_reg,
  output logic [AW-1:0] a_next,
  output logic [N-1:0]  q_reg_next,
  output logic          q0_next
);

  logic [AW-1:0] m_ext;
  logic [AW-1:0] m_neg;
  logic [AW-1:0] sum;

`ifdef BOOTH_RADIX4_EN

  logic [AW-1:0] m2;
  logic [AW-1:0] m2_neg;
  int            digit;

  assign m_ext  = {m_reg[N-1], m_reg};
  assign m_neg  = ~m_ext + AW'(1);
  assign m2     = {m_ext[AW-2:0], 1'b0};
  assign m2_neg = {m_neg[AW-2:0], 1'b0};

  // Select 0, +/-M or +/-2M from the recoded digit and add it to the accumulator
  always_comb begin
    digit = R4_DIGIT[{q_reg[1], q_reg[0], q0}];
    sum   = a;
    case (digit)
      1:       sum = a + m_ext;
      2:       sum = a + m2;
      -1:      sum = a + m_neg;
      -2:      sum = a + m2_neg;
      default: sum = a;
    endcase
  end

  assign a_next     = {{2{sum[AW-1]}}, sum[AW-1:2]};
  assign q_reg_next = {sum[1:0], q_reg[N-1:2]};
  assign q0_next    = q_reg[1];

`else

  assign m_ext = m_reg;
  assign m_neg = ~m_ext + AW'(1);

  // Add or subtract the multiplicand depending on the current bit pair
  always_comb begin
    sum = a;
    case ({q_reg[0], q0})
      2'b01:   sum = a + m_ext;
      2'b10:   sum = a + m_neg;
      default: sum = a;
    endcase
  end

  assign a_next     = {sum[AW-1], sum[AW-1:1]};
  assign q_reg_next = {sum[0], q_reg[N-1:1]};
  assign q0_next    = q_reg[0];

`endif

endmodule

// File: rtl/booth_mult_seq.sv
// booth_mult_seq: sequential Booth multiplier with valid/ready handshakes on both sides.
// Build option: BOOTH_RADIX4_EN switches to radix-4 recoding (WIDTH must then be even).
module booth_mult_seq
  import booth_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input logic             clk,
  input logic             rst,
  booth_mult_seq_if.slave bus
);

  localparam int N    = booth_n(WIDTH);
  localparam int AW   = booth_aw(WIDTH);
  localparam int ITER = booth_iter(WIDTH);
  localparam int CW   = $clog2(ITER + 1);
  localparam logic [CW-1:0] LAST_COUNT = CW'(ITER - 1);

  generate
    if (WIDTH < 2) begin : g_width_check
      $error("booth_mult_seq: WIDTH must be at least 2");
    end
`ifdef BOOTH_RADIX4_EN
    if ((WIDTH % 2) != 0) begin : g_even_check
      $error("booth_mult_seq: radix-4 build requires an even WIDTH");
    end
`endif
  endgenerate

  state_t             state;
  state_t             state_next;
  logic               accept;
  logic [AW-1:0]      a_reg;
  logic [AW-1:0]      a_step;
  logic [N-1:0]       q_reg;
  logic [N-1:0]       q_step;
  logic [N-1:0]       m_reg;
  logic               q0_reg;
  logic               q0_step;
  logic [CW-1:0]      count;
  logic [2*WIDTH-1:0] result_reg;

  booth_step #(
    .N  (N),
    .AW (AW)
  ) u_step (
    .a          (a_reg),
    .q_reg      (q_reg),
    .q0         (q0_reg),
    .m_reg      (m_reg),
    .a_next     (a_step),
    .q_reg_next (q_step),
    .q0_next    (q0_step)
  );

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; clear beats both operand accept and result handoff
  always_comb begin
    state_next = state;
    accept     = 1'b0;
    case (state)
      IDLE: begin
        if (!bus.clear && bus.in_valid) begin
          accept     = 1'b1;
          state_next = CALC;
        end
      end
      CALC: begin
        if (bus.clear) begin
          state_next = IDLE;
        end else if (count == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        if (bus.clear || bus.out_ready) begin
          state_next = IDLE;
        end
      end
      default: state_next = IDLE;
    endcase
  end

  // Operand capture, per-cycle Booth step and result load on the final step
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_reg      <= '0;
      q_reg      <= '0;
      q0_reg     <= 1'b0;
      m_reg      <= '0;
      count      <= '0;
      result_reg <= '0;
    end else if (accept) begin
      a_reg  <= '0;
      q0_reg <= 1'b0;
      count  <= LAST_COUNT;
      m_reg  <= {{(N-WIDTH){bus.is_signed & bus.M[WIDTH-1]}}, bus.M};
      q_reg  <= {{(N-WIDTH){bus.is_signed & bus.Q[WIDTH-1]}}, bus.Q};
    end else if (state == CALC && !bus.clear) begin
      a_reg  <= a_step;
      q_reg  <= q_step;
      q0_reg <= q0_step;
      count  <= count - CW'(1);
      if (count == '0) begin
        result_reg <= (2*WIDTH)'({a_step, q_step});
      end
    end
  end

  assign bus.in_ready  = (state == IDLE);
  assign bus.out_valid = (state == DONE);
  assign bus.busy      = (state != IDLE);
  assign bus.result    = result_reg;

endmodule

// File: tb/tb_booth_mult_seq.sv
// tb_booth_mult_seq: scoreboard bench for booth_mult_seq (WIDTH=8).
// Honours BOOTH_RADIX4_EN for the expected latency.
module tb_booth_mult_seq;

  localparam int W = 8;
`ifdef BOOTH_RADIX4_EN
  localparam int LAT = (W + 2) / 2;
`else
  localparam int LAT = W + 1;
`endif

  logic clk = 1'b0;
  logic rst;
  int   cyc = 0;
  int   accept_cyc = 0;
  int   tests_run = 0;
  int   tests_failed = 0;
  logic [2*W-1:0] sb[$];

  booth_mult_seq_if #(.WIDTH(W)) bus ();

  booth_mult_seq #(.WIDTH(W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout required completion");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    tests_run++;
    if (actual !== expected) begin
      tests_failed++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  function automatic logic [2*W-1:0] expProd(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
    logic [2*W-1:0] me;
    logic [2*W-1:0] qe;
    me = s ? {{W{m[W-1]}}, m} : {{W{1'b0}}, m};
    qe = s ? {{W{q[W-1]}}, q} : {{W{1'b0}}, q};
    return me * qe;
  endfunction

  task automatic applyStimulus(input logic [W-1:0] m, input logic [W-1:0] q, input logic s, input bit track);
    int n = 0;
    bus.M = m;
    bus.Q = q;
    bus.is_signed = s;
    bus.in_valid = 1'b1;
    while (!bus.in_ready && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("in_ready_wait", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;
    accept_cyc = cyc;
    bus.in_valid = 1'b0;
    bus.M = ~m;
    bus.Q = ~q;
    bus.is_signed = ~s;
    if (track) sb.push_back(expProd(m, q, s));
    checkOutput("busy_after_accept", 32'(bus.busy), 32'd1);
  endtask

  task automatic waitOutValid();
    int n = 0;
    while (!bus.out_valid && n < 200) begin
      @(posedge clk); #1;
      n++;
    end
    checkOutput("out_valid_wait", 32'(bus.out_valid), 32'd1);
    checkOutput("latency", 32'(cyc - accept_cyc), 32'(LAT));
  endtask

  task automatic popCompare(output logic [2*W-1:0] exp_val);
    if (sb.size() == 0) begin
      checkOutput("scoreboard_empty", 32'(sb.size()), 32'd1);
      exp_val = '0;
    end else begin
      exp_val = sb.pop_front();
      checkOutput("result", 32'(bus.result), 32'(exp_val));
    end
  endtask

  task automatic consume(input logic [2*W-1:0] exp_val);
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.out_ready = 1'b0;
    checkOutput("out_valid_after_handshake", 32'(bus.out_valid), 32'd0);
    checkOutput("in_ready_after_handshake", 32'(bus.in_ready), 32'd1);
    checkOutput("result_held_idle", 32'(bus.result), 32'(exp_val));
  endtask

  task automatic runOp(input logic [W-1:0] m, input logic [W-1:0] q, input logic s);
    logic [2*W-1:0] exp_val;
    applyStimulus(m, q, s, 1'b1);
    waitOutValid();
    popCompare(exp_val);
    consume(exp_val);
  endtask

  initial begin
    logic [2*W-1:0] exp_val;
    int seen;

    rst = 1'b1;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    bus.is_signed = 1'b0;
    bus.M = '0;
    bus.Q = '0;
    bus.out_ready = 1'b0;
    #1;
    checkOutput("reset_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("reset_result", 32'(bus.result), 32'd0);
    checkOutput("reset_in_ready", 32'(bus.in_ready), 32'd1);
    checkOutput("reset_busy", 32'(bus.busy), 32'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Directed vectors
    runOp(8'h05, 8'hFD, 1'b1);
    runOp(8'h80, 8'h80, 1'b1);
    runOp(8'h80, 8'h7F, 1'b1);
    runOp(8'hFF, 8'hFF, 1'b0);
    runOp(8'hC8, 8'h03, 1'b0);

    // Backpressure: result waits for out_ready, new operands ignored
    applyStimulus(8'h12, 8'h34, 1'b0, 1'b1);
    waitOutValid();
    popCompare(exp_val);
    bus.in_valid = 1'b1;
    bus.M = 8'hAA;
    bus.Q = 8'h55;
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      checkOutput("bp_out_valid", 32'(bus.out_valid), 32'd1);
      checkOutput("bp_result", 32'(bus.result), 32'(exp_val));
      checkOutput("bp_in_ready", 32'(bus.in_ready), 32'd0);
    end
    bus.in_valid = 1'b0;
    consume(exp_val);
    runOp(8'h07, 8'h07, 1'b1);

    // Abort with clear in the middle of the computation
    applyStimulus(8'h0B, 8'h0D, 1'b1, 1'b0);
    repeat (3) @(posedge clk);
    #1 bus.clear = 1'b1;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    checkOutput("clear_busy", 32'(bus.busy), 32'd0);
    checkOutput("clear_in_ready", 32'(bus.in_ready), 32'd1);
    seen = 0;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    checkOutput("clear_no_out_valid", 32'(seen), 32'd0);
    checkOutput("clear_result_kept", 32'(bus.result), 32'h0031);

    // clear in IDLE blocks an accept in the same cycle
    bus.clear = 1'b1;
    bus.in_valid = 1'b1;
    bus.M = 8'h01;
    bus.Q = 8'h01;
    @(posedge clk); #1;
    bus.clear = 1'b0;
    bus.in_valid = 1'b0;
    checkOutput("clear_idle_busy", 32'(bus.busy), 32'd0);

    // Asynchronous reset mid-computation
    applyStimulus(8'h33, 8'h44, 1'b0, 1'b0);
    repeat (3) @(posedge clk);
    #3 rst = 1'b1;
    #1;
    checkOutput("async_rst_result", 32'(bus.result), 32'd0);
    checkOutput("async_rst_out_valid", 32'(bus.out_valid), 32'd0);
    checkOutput("async_rst_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); #1 rst = 1'b0;

    runOp(8'hC8, 8'h03, 1'b0);

    // Random operands in both modes
    for (int i = 0; i < 8; i++) begin
      runOp(W'($urandom), W'($urandom), 1'($urandom_range(0, 1)));
    end

    checkOutput("scoreboard_drained", 32'(sb.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/booth_mult_seq.md
Name: booth_mult_seq

Overview:
- Parametrised sequential Booth multiplier: WIDTH-bit operands, 2*WIDTH-bit product, per-transaction signed/unsigned mode.
- One iteration per clock. Valid/ready handshake on both input and output, so it can sit directly in datapath pipelines that apply backpressure.
- Generalises the fixed 6-bit signed radix-2 Booth unit in width, signedness and flow control, and adds an optional radix-4 mode.

Parameters:
- WIDTH, 8, operand width; must be >= 2 (even when BOOTH_RADIX4_EN is defined).

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  reset, asynchronous, active-high.
- clear  in  1  synchronous abort; returns the block to IDLE.
- in_valid  in  1  operands present.
- in_ready  out  1  block can accept operands; equals state==IDLE.
- is_signed  in  1  1 = two's-complement operands, 0 = unsigned; sampled on accept.
- M  in  WIDTH  multiplicand.
- Q  in  WIDTH  multiplier.
- out_valid  out  1  result valid; held until out_ready.
- out_ready  in  1  consumer accepts the result.
- result  out  2*WIDTH  product.
- busy  out  1  high in CALC or DONE.

Behaviour:
- Reset (async, rst=1):
  - state=IDLE; out_valid=0; result=0; busy=0; in_ready=1.
  - All internal registers are cleared.
  - Reset asserted mid-operation discards the operation with no output.
- States:
  - IDLE: in_ready=1. On in_valid&&in_ready go to CALC. On that edge:
    - A=0, q0=0.
    - Internal width N=WIDTH+1. Mreg and Qreg are extended to N bits: sign-extended if is_signed=1, zero-extended if is_signed=0.
    - count=ITER-1, where ITER=N.
  - CALC: one Booth step per cycle.
    - Compute A'=A+Mreg for {q[0],q0}=01, A-Mreg for 10, A otherwise. Subtraction uses the two's complement of Mreg, N bits.
    - Arithmetic right shift of {A',Qreg,q0} by 1. The sign of A' is replicated.
    - count decrements by 1. On the step with count==0: load result = low 2*WIDTH bits of {A,Qreg} after that step, set out_valid=1, go to DONE.
  - DONE: out_valid=1, result stable. On out_ready=1, clear out_valid on the next edge and go to IDLE.
- Latency: out_valid rises exactly ITER clocks after the accept edge. Throughput is one product per ITER+2 cycles with out_ready tied high.
- result keeps its last value after a handshake until the next result load. It does not change in IDLE or CALC.
- Inputs (M, Q, is_signed) are ignored outside the accept cycle.
- clear:
  - In CALC or DONE: next state IDLE, out_valid=0, result unchanged.
  - clear has priority over in_valid and out_ready in the same cycle. With clear=1 in IDLE, no operands are accepted.
- Boundary cases:
  - Most-negative × most-negative (signed) is exact thanks to the N=WIDTH+1 extension.
  - Unsigned all-ones × all-ones is exact.
- Arithmetic: all adds are N bits with carry-out discarded. No overflow flag; the 2*WIDTH result is always exact.

Optional Feature:
- Macro BOOTH_RADIX4_EN.
- Defined:
  - Modified Booth radix-4 recoding with N=WIDTH+2 and ITER=N/2.
  - Each step examines {q[1],q[0],q0} and selects 0, ±Mreg or ±2Mreg. A is widened by one guard bit for ±2M.
  - Each step shifts right by 2, arithmetic.
  - Latency is ITER=(WIDTH+2)/2 cycles.
  - Compile-time check fails if WIDTH is odd.
- Undefined: radix-2 as described above.
- Handshake, clear and reset behaviour are identical in both builds; only the latency differs.

Decomposition:
- Package booth_pkg holds:
  - state enum {IDLE, CALC, DONE};
  - function booth_iter(WIDTH) returning ITER for the selected radix;
  - the recoding constants (radix-4 digit table).
- One sub-module, booth_step: a purely combinational single iteration. Inputs A, Qreg, q0, Mreg; outputs the next A, Qreg and q0. It is parametrised on N and compiled for radix-2 or radix-4 under the same macro.
- booth_mult_seq holds the FSM, counter, operand registers and output register.

Test Plan (WIDTH=8, radix-2 unless noted):
- Signed 5 × −3 (M=0x05, Q=0xFD, is_signed=1) -> result=0xFFF1; out_valid rises 9 cycles after the accept edge.
- Signed −128 × −128 (0x80, 0x80) -> 0x4000. Signed −128 × 127 -> 0xC080.
- Unsigned 255 × 255 (0xFF, 0xFF, is_signed=0) -> 0xFE01. Unsigned 200 × 3 -> 0x0258.
- Backpressure: out_ready=0 for 5 cycles after out_valid -> result and out_valid held, in_ready=0, new in_valid ignored. out_ready=1 -> IDLE next cycle; back-to-back second op 7 × 7 -> 0x0031.
- Abort/reset:
  - clear at iteration 4 -> IDLE next cycle, out_valid never rises, result keeps the previous value.
  - rst mid-CALC -> result=0, out_valid=0 immediately, without waiting for a clock edge.
- BOOTH_RADIX4_EN build: the same vectors give identical results, with out_valid rising 5 cycles after accept.
